// File: rtl/sram_resp_model.sv
// Cycle-level behavioural responder for an asynchronous 16-bit SRAM.
// All pin inputs are registered once; every response trails the pins by one clock.
module sram_resp_model #(
    parameter int DEPTH_W = 8,
    parameter int RD_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] ad,
    input  logic        we_n,
    input  logic        oe_n,
    input  logic        ce_a_n,
    input  logic        ub_a_n,
    input  logic        lb_a_n,
    inout  wire  [15:0] dio_a,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        err_oob,
    output logic        err_cont
);

    typedef enum logic [1:0] {
        IDLE,
        WR_ACTIVE,
        RD_WAIT,
        RD_DRIVE
    } state_t;

    localparam int WORDS = 2 ** DEPTH_W;

    logic [15:0] mem_q [WORDS];

    logic [17:0] ad_q;
    logic        we_n_q;
    logic        oe_n_q;
    logic        ce_n_q;
    logic        ub_n_q;
    logic        lb_n_q;
    logic [15:0] din_q;

    state_t      state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [17:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wub_n_q, wub_n_d;
    logic        wlb_n_q, wlb_n_d;
    logic [17:0] raddr_q, raddr_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic        oob_q, oob_d;
    logic        cont_q, cont_d;

    logic        wr_req;
    logic        rd_req;
    logic        capture;
    logic        start_rd;
    logic        commit;
    logic        mem_wr;
    logic        drive;

    function automatic logic out_of_range(input logic [17:0] a);
        return (a >> DEPTH_W) != 18'd0;
    endfunction

    assign wr_req = !ce_n_q && !we_n_q;
    assign rd_req = !ce_n_q && we_n_q && !oe_n_q;

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wub_n_d  = wub_n_q;
        wlb_n_d  = wlb_n_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        oob_d    = oob_q;
        cont_d   = cont_q;
        capture  = 1'b0;
        start_rd = 1'b0;
        commit   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WR_ACTIVE;
                    capture = 1'b1;
                end else if (rd_req) begin
                    state_d  = RD_WAIT;
                    start_rd = 1'b1;
                end
            end
            WR_ACTIVE: begin
                if (we_n_q || ce_n_q) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (ce_n_q) begin
                    state_d = IDLE;
                end else if (!we_n_q) begin
                    // Controller started driving while we may own the bus.
                    if (state_q == RD_DRIVE) cont_d = 1'b1;
                    state_d = WR_ACTIVE;
                    capture = 1'b1;
                end else if (oe_n_q) begin
                    state_d = IDLE;
                end else if (ad_q != raddr_q) begin
                    state_d  = RD_WAIT;
                    start_rd = 1'b1;
                end else if (state_q == RD_WAIT) begin
                    if (lat_q == 3'(RD_LAT)) begin
                        state_d  = RD_DRIVE;
                        rdata_d  = out_of_range(raddr_q) ? 16'hFFFF
                                 : mem_q[raddr_q[DEPTH_W-1:0]];
                        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
                    end else begin
                        lat_d = lat_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            waddr_d = ad_q;
            wdata_d = din_q;
            wub_n_d = ub_n_q;
            wlb_n_d = lb_n_q;
            if (out_of_range(ad_q)) oob_d = 1'b1;
        end

        if (start_rd) begin
            raddr_d = ad_q;
            lat_d   = 3'd1;
            if (out_of_range(ad_q)) oob_d = 1'b1;
        end

        if (commit && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ad_q     <= '0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ce_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            din_q    <= '0;
            state_q  <= IDLE;
            lat_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wub_n_q  <= 1'b1;
            wlb_n_q  <= 1'b1;
            raddr_q  <= '0;
            rdata_q  <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            oob_q    <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            ad_q     <= ad;
            we_n_q   <= we_n;
            oe_n_q   <= oe_n;
            ce_n_q   <= ce_a_n;
            ub_n_q   <= ub_a_n;
            lb_n_q   <= lb_a_n;
            din_q    <= dio_a;
            state_q  <= state_d;
            lat_q    <= lat_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wub_n_q  <= wub_n_d;
            wlb_n_q  <= wlb_n_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            oob_q    <= oob_d;
            cont_q   <= cont_d;
        end
    end

    // Memory has no reset; a reset edge suppresses the pending commit.
    assign mem_wr = commit && reset && !out_of_range(waddr_q);

    always_ff @(posedge clk) begin
        if (mem_wr && !wub_n_q) mem_q[waddr_q[DEPTH_W-1:0]][15:8] <= wdata_q[15:8];
        if (mem_wr && !wlb_n_q) mem_q[waddr_q[DEPTH_W-1:0]][7:0]  <= wdata_q[7:0];
    end

    // Release combinationally as soon as the registered pins stop qualifying the read.
    assign drive = reset && (state_q == RD_DRIVE) && !ce_n_q && we_n_q
                 && !oe_n_q && (ad_q == raddr_q);

    assign dio_a[15:8] = (drive && !ub_n_q) ? rdata_q[15:8] : 8'hzz;
    assign dio_a[7:0]  = (drive && !lb_n_q) ? rdata_q[7:0]  : 8'hzz;

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
    assign err_oob  = oob_q;
    assign err_cont = cont_q;

endmodule
